// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
// Contents: FSM state enum, SPI clock-divider landmarks, frame length and a helper
// that builds the ADC command word for a channel.
package a2d_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFrm1,
    StGap,
    StFrm2
  } a2d_state_e;

  // SCLK = div[4]; loading DIV_START leaves SCLK high for the front porch.
  localparam logic [4:0] DIV_START  = 5'b10111;
  // SCLK about to rise: capture MISO.
  localparam logic [4:0] DIV_SAMPLE = 5'b01111;
  // SCLK about to fall: shift. Also the idle/frozen value.
  localparam logic [4:0] DIV_SHIFT  = 5'b11111;

  localparam int unsigned FRAME_BITS = 16;

  // ADC command: channel number in bits [13:11], everything else zero.
  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_spi_intf_if.sv
// Request/response handshake between the slider/pot scanner and the A2D responder.
// Signals: strt_cnv (request pulse), chnnl (channel), cnv_cmplt (result valid level),
// res (12-bit result).
// Modports: master = scanner side, slave = A2D responder side.
interface a2d_spi_intf_if;

  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (
    output strt_cnv,
    output chnnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt_cnv,
    input  chnnl,
    output cnv_cmplt,
    output res
  );

endinterface

// File: rtl/a2d_spi_shifter.sv
// SPI frame engine: SCLK divider, bit counter, MISO sample flop and 16-bit shifter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_i         start a frame: load load_word_i, restart divider at the porch
//   load_word_i    command word shifted out on MOSI
//   run_i          frame in progress (chip select asserted)
//   miso_i         serial data from the ADC
//   sclk_o         SPI clock, idles high
//   mosi_o         serial data to the ADC (shifter MSB)
//   frame_done_o   high in the cycle whose edge performs the 16th shift
//   rx_word_o      low 12 bits of the shifter (received data once the frame ends)
module a2d_spi_shifter
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_word_i,
  input  logic        run_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        frame_done_o,
  output logic [11:0] rx_word_o
);

  logic [4:0]  div_q, div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_smp_q, miso_smp_d;
  logic [15:0] shft_q, shft_d;

  logic sample_evt;
  logic shift_evt;

  assign sample_evt   = run_i && (div_q == DIV_SAMPLE);
  // The fall right after the porch has no sampled bit behind it yet.
  assign shift_evt    = run_i && (div_q == DIV_SHIFT) && (bit_cnt_q != 5'd0);
  assign frame_done_o = shift_evt && (bit_cnt_q == 5'(FRAME_BITS));

  always_comb begin
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    miso_smp_d = miso_smp_q;
    shft_d     = shft_q;
    if (load_i) begin
      div_d     = DIV_START;
      bit_cnt_d = 5'd0;
      shft_d    = load_word_i;
    end else begin
      // Freeze on the last shift so SCLK stays high instead of emitting a stray fall.
      if (run_i && !frame_done_o) begin
        div_d = div_q + 5'd1;
      end else begin
        div_d = DIV_SHIFT;
      end
      if (sample_evt) begin
        miso_smp_d = miso_i;
        bit_cnt_d  = bit_cnt_q + 5'd1;
      end
      if (shift_evt) begin
        shft_d = {shft_q[14:0], miso_smp_q};
      end
      if (frame_done_o) begin
        bit_cnt_d = 5'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DIV_SHIFT;
      bit_cnt_q  <= 5'd0;
      miso_smp_q <= 1'b0;
      shft_q     <= 16'h0000;
    end else begin
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_smp_q <= miso_smp_d;
      shft_q     <= shft_d;
    end
  end

  assign sclk_o    = div_q[4];
  assign mosi_o    = shft_q[15];
  assign rx_word_o = shft_q[11:0];

endmodule

// File: rtl/a2d_spi_intf.sv
// A2D responder: on an accepted strt_cnv, runs two 16-bit SPI frames carrying the
// channel command, separated by a chip-select gap, and returns the second frame's
// low 12 bits on res with cnv_cmplt.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req          scanner handshake (slave modport: strt_cnv, chnnl in; cnv_cmplt, res out)
//   MISO         ADC serial data out
//   a2d_SS_n     ADC chip select, active-low
//   SCLK         SPI clock, idles high
//   MOSI         SPI data to the ADC
module a2d_spi_intf
  import a2d_pkg::*;
#(
  parameter int unsigned GAP_CLKS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  a2d_spi_intf_if.slave        req,
  input  logic                 MISO,
  output logic                 a2d_SS_n,
  output logic                 SCLK,
  output logic                 MOSI
);

  localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CLKS - 1);

  a2d_state_e      state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            ss_n_q, ss_n_d;
  logic [11:0]     res_q, res_d;
  logic            cmplt_q, cmplt_d;
  logic [2:0]      ch_q, ch_d;

  logic        load;
  logic [15:0] load_word;
  logic        frame_done;
  logic [11:0] rx_word;

  a2d_spi_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .load_word_i  (load_word),
    .run_i        (~ss_n_q),
    .miso_i       (MISO),
    .sclk_o       (SCLK),
    .mosi_o       (MOSI),
    .frame_done_o (frame_done),
    .rx_word_o    (rx_word)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    ss_n_d    = ss_n_q;
    res_d     = res_q;
    cmplt_d   = cmplt_q;
    ch_d      = ch_q;
    load      = 1'b0;
    load_word = cmd_word(ch_q);
    unique case (state_q)
      StIdle: begin
        if (req.strt_cnv) begin
          ch_d      = req.chnnl;
          load      = 1'b1;
          load_word = cmd_word(req.chnnl);
          ss_n_d    = 1'b0;
          cmplt_d   = 1'b0;
          state_d   = StFrm1;
        end
      end
      StFrm1: begin
        if (frame_done) begin
          ss_n_d  = 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          load    = 1'b1;
          ss_n_d  = 1'b0;
          state_d = StFrm2;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StFrm2: begin
        // Chip select drops on the 16th shift; the shifter holds the full word one
        // cycle later, and staying here that cycle keeps strt_cnv ignored.
        if (frame_done) begin
          ss_n_d = 1'b1;
        end else if (ss_n_q) begin
          res_d   = rx_word;
          cmplt_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      ss_n_q  <= 1'b1;
      res_q   <= 12'h000;
      cmplt_q <= 1'b0;
      ch_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ss_n_q  <= ss_n_d;
      res_q   <= res_d;
      cmplt_q <= cmplt_d;
      ch_q    <= ch_d;
    end
  end

  assign a2d_SS_n      = ss_n_q;
  assign req.cnv_cmplt = cmplt_q;
  assign req.res       = res_q;

endmodule
